// File: rtl/cluster_unpacker_if.sv
// Cluster word / frame strobe bus into the unpacker and the reconstructed map out of it.
// master drives clusters and reads maps; slave is the unpacker.
interface cluster_unpacker_if #(
    parameter int MXSTRIPS = 1536,
    parameter int MXADRB   = 11,
    parameter int MXCNTB   = 3
) ();
    logic                         frame_strobe;
    logic                         clst_valid;
    logic [MXADRB-1:0]            clst_adr;
    logic [MXCNTB-1:0]            clst_cnt;

    logic [MXSTRIPS-1:0]          vpfs;
    logic [MXSTRIPS*MXCNTB-1:0]   cnts;
    logic [MXSTRIPS-1:0]          hits;
    logic [3:0]                   n_clusters;
    logic                         overflow;
    logic                         bad_adr;
    logic                         out_valid;

    modport master (
        output frame_strobe, clst_valid, clst_adr, clst_cnt,
        input  vpfs, cnts, hits, n_clusters, overflow, bad_adr, out_valid
    );

    modport slave (
        input  frame_strobe, clst_valid, clst_adr, clst_cnt,
        output vpfs, cnts, hits, n_clusters, overflow, bad_adr, out_valid
    );
endinterface

// File: rtl/cluster_unpacker.sv
// Rebuilds per-BX strip maps (vpfs/cnts/hits) from serial (address, count) cluster words;
// the accumulated map is emitted and the accumulator cleared on each frame strobe.
module cluster_unpacker #(
    parameter int MXSTRIPS   = 1536,
    parameter int MXCLUSTERS = 8,
    parameter int MXADRB     = 11,
    parameter int MXCNTB     = 3
) (
    input logic                clock4x,
    input logic                global_reset_n,
    cluster_unpacker_if.slave  bus
);
    localparam int ADRX_W  = MXADRB + 1;
    localparam int MAXSPAN = 2 ** MXCNTB;

    logic [MXSTRIPS-1:0]        acc_vpfs, nxt_vpfs;
    logic [MXSTRIPS*MXCNTB-1:0] acc_cnts, nxt_cnts;
    logic [MXSTRIPS-1:0]        acc_hits, nxt_hits;
    logic [3:0]                 acc_n,    nxt_n;
    logic                       acc_ovf,  nxt_ovf;
    logic                       acc_bad,  nxt_bad;

    // Next accumulator value including this cycle's cluster, so a cluster that
    // coincides with the strobe lands in the closing frame.
    always_comb begin
        logic [ADRX_W-1:0] strip;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        nxt_vpfs = acc_vpfs;
        nxt_cnts = acc_cnts;
        nxt_hits = acc_hits;
        nxt_n    = acc_n;
        nxt_ovf  = acc_ovf;
        nxt_bad  = acc_bad;
        strip    = '0;
        if (bus.clst_valid) begin
            if (ADRX_W'(bus.clst_adr) >= ADRX_W'(MXSTRIPS)) begin
                nxt_bad = 1'b1;
            end else if (acc_n == 4'(MXCLUSTERS)) begin
                nxt_ovf = 1'b1;
            end else begin
                nxt_vpfs[bus.clst_adr] = 1'b1;
                nxt_cnts[int'(bus.clst_adr)*MXCNTB +: MXCNTB] = bus.clst_cnt;
                // Expansion clips at the last strip instead of wrapping.
                for (int k = 0; k < MAXSPAN; k++) begin
                    strip = ADRX_W'(bus.clst_adr) + ADRX_W'(k);
                    if (k <= int'(bus.clst_cnt) && strip < ADRX_W'(MXSTRIPS))
                        nxt_hits[strip[MXADRB-1:0]] = 1'b1;
                end
                nxt_n = acc_n + 4'd1;
            end
        end
    end

    // NOTE: sequential state is always written with non-blocking assignments.
    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            acc_vpfs <= '0;
            acc_cnts <= '0;
            acc_hits <= '0;
            acc_n    <= '0;
            acc_ovf  <= 1'b0;
            acc_bad  <= 1'b0;
        end else if (bus.frame_strobe) begin
            acc_vpfs <= '0;
            acc_cnts <= '0;
            acc_hits <= '0;
            acc_n    <= '0;
            acc_ovf  <= 1'b0;
            acc_bad  <= 1'b0;
        end else begin
            acc_vpfs <= nxt_vpfs;
            acc_cnts <= nxt_cnts;
            acc_hits <= nxt_hits;
            acc_n    <= nxt_n;
            acc_ovf  <= nxt_ovf;
            acc_bad  <= nxt_bad;
        end
    end

    // Output map holds between strobes.
    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            bus.vpfs       <= '0;
            bus.cnts       <= '0;
            bus.hits       <= '0;
            bus.n_clusters <= '0;
            bus.overflow   <= 1'b0;
            bus.bad_adr    <= 1'b0;
            bus.out_valid  <= 1'b0;
        end else begin
            bus.out_valid <= bus.frame_strobe;
            if (bus.frame_strobe) begin
                bus.vpfs       <= nxt_vpfs;
                bus.cnts       <= nxt_cnts;
                bus.hits       <= nxt_hits;
                bus.n_clusters <= nxt_n;
                bus.overflow   <= nxt_ovf;
                bus.bad_adr    <= nxt_bad;
            end
        end
    end
endmodule

// File: tb/tb_cluster_unpacker.sv
// Randomized and directed bench for cluster_unpacker against an array-based frame model.
// A compare process checks every output on every falling edge.
module tb_cluster_unpacker;
    localparam int MXSTRIPS   = 1536;
    localparam int MXCLUSTERS = 8;
    localparam int MXADRB     = 11;
    localparam int MXCNTB     = 3;
    localparam int CW         = MXSTRIPS * MXCNTB;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    cluster_unpacker_if #(.MXSTRIPS(MXSTRIPS), .MXADRB(MXADRB), .MXCNTB(MXCNTB)) bus ();

    cluster_unpacker #(
        .MXSTRIPS(MXSTRIPS), .MXCLUSTERS(MXCLUSTERS), .MXADRB(MXADRB), .MXCNTB(MXCNTB)
    ) dut (
        .clock4x        (clk),
        .global_reset_n (rst_n),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: per-strip arrays for the open frame, packed vectors for the emitted one.
    bit            m_vpfs [MXSTRIPS];
    int            m_cnt  [MXSTRIPS];
    bit            m_hits [MXSTRIPS];
    int            m_n;
    bit            m_ovf, m_bad;
    logic [MXSTRIPS-1:0] e_vpfs, e_hits;
    logic [CW-1:0]       e_cnts;
    int            e_n;
    bit            e_ovf, e_bad, e_valid;

    task automatic clear_frame();
        for (int i = 0; i < MXSTRIPS; i++) begin
            m_vpfs[i] = 0; m_cnt[i] = 0; m_hits[i] = 0;
        end
        m_n = 0; m_ovf = 0; m_bad = 0;
    endtask

    initial begin
        clear_frame();
        e_vpfs = '0; e_hits = '0; e_cnts = '0; e_n = 0; e_ovf = 0; e_bad = 0; e_valid = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                clear_frame();
                e_vpfs = '0; e_hits = '0; e_cnts = '0; e_n = 0; e_ovf = 0; e_bad = 0; e_valid = 0;
            end else begin
                if (bus.clst_valid) begin
                    int a, c;
                    a = int'(bus.clst_adr);
                    c = int'(bus.clst_cnt);
                    if (a >= MXSTRIPS) m_bad = 1;
                    else if (m_n == MXCLUSTERS) m_ovf = 1;
                    else begin
                        m_vpfs[a] = 1;
                        m_cnt[a]  = c;
                        for (int s = a; s <= a + c && s < MXSTRIPS; s++) m_hits[s] = 1;
                        m_n++;
                    end
                end
                if (bus.frame_strobe) begin
                    for (int i = 0; i < MXSTRIPS; i++) begin
                        e_vpfs[i] = m_vpfs[i];
                        e_hits[i] = m_hits[i];
                        e_cnts[i*MXCNTB +: MXCNTB] = 3'(m_cnt[i]);
                    end
                    e_n = m_n; e_ovf = m_ovf; e_bad = m_bad; e_valid = 1;
                    clear_frame();
                end else begin
                    e_valid = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        int idx;
        tests++;
        if (act !== exp) begin
            failed++;
            idx = 0;
            for (int i = CW - 1; i >= 0; i--) if (act[i] !== exp[i]) idx = i;
            $display("FAIL %s: first bad bit %0d got %b expected %b (ones got %0d expected %0d) at %0t",
                     name, idx, act[idx], exp[idx], $countones(act), $countones(exp), $time);
        end
    endtask

    // Compare process: outputs must match the model every cycle (they hold between strobes).
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("out_valid_in_reset", 32'(bus.out_valid), 32'd0);
                check("n_in_reset", 32'(bus.n_clusters), 32'd0);
            end else begin
                check("out_valid", 32'(bus.out_valid), 32'(e_valid));
                check("n_clusters", 32'(bus.n_clusters), 32'(e_n));
                check("overflow", 32'(bus.overflow), 32'(e_ovf));
                check("bad_adr", 32'(bus.bad_adr), 32'(e_bad));
                check_vec("vpfs", CW'(bus.vpfs), CW'(e_vpfs));
                check_vec("hits", CW'(bus.hits), CW'(e_hits));
                check_vec("cnts", bus.cnts, e_cnts);
            end
        end
    end

    // One stimulus cycle; returns 1 time unit after the edge that samples it.
    task automatic drive(input bit v, input int adr, input int cnt, input bit strb);
        bus.clst_valid   = v;
        bus.clst_adr     = MXADRB'(adr);
        bus.clst_cnt     = MXCNTB'(cnt);
        bus.frame_strobe = strb;
        @(posedge clk);
        #1;
        bus.clst_valid   = 1'b0;
        bus.clst_adr     = '0;
        bus.clst_cnt     = '0;
        bus.frame_strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0);
    endtask

    initial begin
        tests = 0; failed = 0;
        rst_n = 1'b0;
        bus.clst_valid = 1'b0; bus.clst_adr = '0; bus.clst_cnt = '0; bus.frame_strobe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_vpfs_ones", 32'($countones(bus.vpfs)), 32'd0);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b1;
        idle(1);

        // First strobe after reset: empty frame with a pulse.
        drive(0, 0, 0, 1);
        check("empty_first_valid", 32'(bus.out_valid), 32'd1);
        check("empty_first_n", 32'(bus.n_clusters), 32'd0);
        idle(1);

        // Single cluster.
        drive(1, 100, 2, 0);
        drive(0, 0, 0, 1);
        check("single_valid", 32'(bus.out_valid), 32'd1);
        check("single_vpfs100", 32'(bus.vpfs[100]), 32'd1);
        check("single_cnts", 32'(bus.cnts[302:300]), 32'd2);
        check("single_hits", 32'(bus.hits[102:100]), 32'b111);
        check("single_hits_ones", 32'($countones(bus.hits)), 32'd3);
        check("single_vpfs_ones", 32'($countones(bus.vpfs)), 32'd1);
        check("single_n", 32'(bus.n_clusters), 32'd1);
        check("single_ovf_bad", {30'd0, bus.overflow, bus.bad_adr}, 32'd0);
        idle(1);
        check("single_valid_drop", 32'(bus.out_valid), 32'd0);
        check("single_hold_n", 32'(bus.n_clusters), 32'd1);

        // Ten clusters: only the first eight are kept.
        for (int i = 0; i < 10; i++) drive(1, i * 10, 0, 0);
        drive(0, 0, 0, 1);
        check("ovf_n", 32'(bus.n_clusters), 32'd8);
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        check("ovf_vpfs70", 32'(bus.vpfs[70]), 32'd1);
        check("ovf_vpfs80_90", {30'd0, bus.vpfs[80], bus.vpfs[90]}, 32'd0);
        check("ovf_vpfs_ones", 32'($countones(bus.vpfs)), 32'd8);

        // Edge clip at the last strip.
        drive(1, 1534, 7, 0);
        drive(0, 0, 0, 1);
        check("clip_hits_top", 32'(bus.hits[1535:1534]), 32'b11);
        check("clip_hits0", 32'(bus.hits[0]), 32'd0);
        check("clip_hits_ones", 32'($countones(bus.hits)), 32'd2);
        check("clip_cnts", 32'(bus.cnts[4604:4602]), 32'd7);

        // Invalid address marker followed by a good cluster.
        drive(1, 'h7FE, 3, 0);
        drive(1, 5, 1, 0);
        drive(0, 0, 0, 1);
        check("bad_flag", 32'(bus.bad_adr), 32'd1);
        check("bad_n", 32'(bus.n_clusters), 32'd1);
        check("bad_vpfs5", 32'(bus.vpfs[5]), 32'd1);
        check("bad_hits", 32'(bus.hits[6:5]), 32'b11);

        // Duplicate address: later cnt wins, hits OR, both counted.
        drive(1, 40, 4, 0);
        drive(1, 40, 1, 0);
        drive(0, 0, 0, 1);
        check("dup_n", 32'(bus.n_clusters), 32'd2);
        check("dup_cnts", 32'(bus.cnts[122:120]), 32'd1);
        check("dup_hits_ones", 32'($countones(bus.hits)), 32'd5);

        // Cluster coincident with strobe, then an empty frame four cycles later.
        drive(1, 20, 0, 1);
        check("coin_vpfs20", 32'(bus.vpfs[20]), 32'd1);
        check("coin_n", 32'(bus.n_clusters), 32'd1);
        idle(3);
        drive(0, 0, 0, 1);
        check("coin_empty_valid", 32'(bus.out_valid), 32'd1);
        check("coin_empty_n", 32'(bus.n_clusters), 32'd0);
        check("coin_empty_vpfs", 32'($countones(bus.vpfs)), 32'd0);

        // Back-to-back strobes.
        drive(1, 300, 3, 0);
        drive(0, 0, 0, 1);
        check("b2b_first_n", 32'(bus.n_clusters), 32'd1);
        drive(0, 0, 0, 1);
        check("b2b_second_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_second_n", 32'(bus.n_clusters), 32'd0);
        check("b2b_second_hits", 32'($countones(bus.hits)), 32'd0);

        // Reset mid-frame discards the partial frame.
        for (int i = 0; i < 3; i++) drive(1, 200 + i * 4, 2, 0);
        rst_n = 1'b0;
        idle(1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b1;
        idle(1);
        drive(0, 0, 0, 1);
        check("rst_frame_valid", 32'(bus.out_valid), 32'd1);
        check("rst_frame_n", 32'(bus.n_clusters), 32'd0);
        check("rst_frame_vpfs", 32'($countones(bus.vpfs)), 32'd0);

        // Randomized frames checked by the compare process.
        for (int f = 0; f < 80; f++) begin
            int ncl, last_adr;
            ncl = $urandom_range(0, 11);
            last_adr = $urandom_range(0, MXSTRIPS - 1);
            for (int c = 0; c < ncl; c++) begin
                int r, adr;
                r = $urandom_range(0, 9);
                case (r)
                    0:       adr = 'h7FE + $urandom_range(0, 1);
                    1:       adr = $urandom_range(MXSTRIPS, 2047);
                    2:       adr = $urandom_range(MXSTRIPS - 8, MXSTRIPS - 1);
                    3:       adr = last_adr;
                    default: adr = $urandom_range(0, MXSTRIPS - 1);
                endcase
                last_adr = adr;
                drive(1, adr, $urandom_range(0, 7), (c == ncl - 1) && ($urandom_range(0, 3) == 0));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            if ($urandom_range(0, 14) == 0) begin
                rst_n = 1'b0;
                idle(1);
                rst_n = 1'b1;
            end
            drive(0, 0, 0, 1);
            if ($urandom_range(0, 5) == 0) drive(0, 0, 0, 1);
            idle($urandom_range(0, 2));
        end

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
